br_param: RTL and testbench
===========================

BR_PARAM -- requirements
Module: br_param

Interface
REQ-001 Parameter WIDTH, default 32, the data width of each register in bits.
REQ-002 Parameter DEPTH, default 32, the number of registers; legal range 2..256.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 always reads zero and ignores writes.
REQ-004 Parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to the read ports.
REQ-005 Localparam AW = $clog2(DEPTH), the address width.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 a1  in  AW  read address, port 1.
REQ-009 a2  in  AW  read address, port 2.
REQ-010 a3  in  AW  write address.
REQ-011 wd3  in  WIDTH  write data.
REQ-012 we  in  1  write enable.
REQ-013 rd1  out  WIDTH  read data, port 1.
REQ-014 rd2  out  WIDTH  read data, port 2.
REQ-015 bs  in  1  busy-set strobe: marks register bsa as pending a result.
REQ-016 bsa  in  AW  busy-set address.
REQ-017 busy1  out  1  pending status of register a1.
REQ-018 busy2  out  1  pending status of register a2.

Function
REQ-019 A write SHALL store wd3 into register a3 on the rising clk edge when we=1.
REQ-020 Reads SHALL be combinational: rdX = reg[aX] with zero cycles of latency.
REQ-021 With ZERO_REG=1: writes to address 0 are dropped, rdX=0 for aX=0, and the busy bit of register 0 never sets.
REQ-022 An address >= DEPTH (DEPTH not a power of two): reads return 0 and busyX=0; writes and busy-sets are ignored.
REQ-023 BYPASS=1: when we=1, a3=aX and the address is writable, rdX=wd3 in the same cycle.
REQ-024 BYPASS=0: rdX returns the pre-write value until after the edge.
REQ-025 Scoreboard: one busy bit per register; bs=1 sets busy[bsa] at the edge.
REQ-026 A write (we=1) SHALL clear busy[a3] at the edge.
REQ-027 When bs and we target the same address in one cycle, set wins: the register ends busy and the data is still written.
REQ-028 busyX = busy[aX]; with BYPASS=1 it is forced to 0 when we=1 and a3=aX, since the value is being forwarded.
REQ-029 Two read ports SHALL read the same address independently and identically.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, clear all registers and busy bits to 0.
REQ-031 During reset, rd1, rd2, busy1 and busy2 read 0, and we and bs are ignored.
REQ-032 Reset deasserting mid-operation SHALL lose no later write: the first edge with rst_n=1 writes normally.

Structure
REQ-033 A shared package br_pkg SHALL hold the default WIDTH/DEPTH constants and a function returning the address width.
REQ-034 The scoreboard SHALL be a sub-module br_scoreboard (DEPTH bits, set/clear ports, two lookups); data storage stays in br_param.
REQ-035 There SHALL be no latches; the bypass and zero-register muxes are generated under their parameters.

Verification
REQ-036 Reset then read all addresses -> every rdX=0 and busyX=0.
REQ-037 we=1, a3=1, wd3=0x0000000A, edge; then a1=1 -> rd1=0x0000000A; a2=2 -> rd2=0.
REQ-038 we=1, a3=0, wd3=0xFFFFFFFF, ZERO_REG=1 -> rd1 at a1=0 stays 0 before and after the edge.
REQ-039 BYPASS=1, we=1, a3=a1=5, wd3=0x1234 -> rd1=0x1234 in the same cycle; BYPASS=0 -> old value until after the edge.
REQ-040 bs=1, bsa=7, edge -> busy1=1 at a1=7; then we=1, a3=7 -> busy1=0 combinationally (BYPASS=1), busy bit clear after the edge; bs and we both on 7 -> stays busy.
REQ-041 DEPTH=24: write to a3=30, then read a1=30 -> rd1=0; rst_n pulsed low mid-cycle -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/br_pkg.sv
// Shared defaults and address-width helper for the br_param register file.
package br_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/br_scoreboard.sv
// Per-register busy bits: set/clear on the clock edge, set wins a same-cycle clash.
// Two combinational lookups; out-of-range addresses read as not busy. No backpressure.
module br_scoreboard
  import br_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set,
  input  logic [AW-1:0]      set_addr,
  input  logic               clr,
  input  logic [AW-1:0]      clr_addr,
  input  logic [1:0][AW-1:0] lk_addr,
  output logic [1:0]         lk_busy
);

  logic [DEPTH-1:0]     busy;
  logic [(1<<AW)-1:0]   busy_pad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set && set_addr == AW'(i)) begin
          busy[i] <= 1'b1;
        end else if (clr && clr_addr == AW'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Zero-padding the vector to the full address space makes holes read as idle.
  always_comb begin
    busy_pad = '0;
    busy_pad[DEPTH-1:0] = busy;
  end

  assign lk_busy[0] = busy_pad[lk_addr[0]];
  assign lk_busy[1] = busy_pad[lk_addr[1]];

endmodule

// File: rtl/br_param.sv
// Parameterised 2-read/1-write register file with busy scoreboard; reads are
// combinational (0 cycles), writes land on the rising edge. No backpressure.
module br_param
  import br_pkg::*;
#(
  parameter int  WIDTH    = DEFAULT_WIDTH,
  parameter int  DEPTH    = DEFAULT_DEPTH,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  input  logic [AW-1:0]    a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             bs,
  input  logic [AW-1:0]    bsa,
  output logic             busy1,
  output logic             busy2
);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic                   wr_ok;
  logic                   set_ok;
  logic [1:0][AW-1:0]     ra;
  logic [1:0]             sb_busy;
  logic [1:0][WIDTH-1:0]  rd_o;
  logic [1:0]             busy_o;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic writable(input logic [AW-1:0] a);
    return in_range(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign wr_ok  = we && writable(a3);
  assign set_ok = bs && writable(bsa);
  assign ra     = {a2, a1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[a3] <= wd3;
    end
  end

  br_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (set_ok),
    .set_addr (bsa),
    .clr      (wr_ok),
    .clr_addr (a3),
    .lk_addr  (ra),
    .lk_busy  (sb_busy)
  );

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] stored;
    logic             hit;

    if (ZERO_REG != 0) begin : g_zero
      assign stored = (in_range(ra[p]) && ra[p] != '0) ? mem[ra[p]] : '0;
    end else begin : g_nozero
      assign stored = in_range(ra[p]) ? mem[ra[p]] : '0;
    end

    // A forwarded value is by definition the result, so it cannot be pending.
    if (BYPASS != 0) begin : g_bypass
      assign hit = wr_ok && (a3 == ra[p]);
    end else begin : g_nobypass
      assign hit = 1'b0;
    end

    assign rd_o[p]   = !rst_n ? '0 : (hit ? wd3 : stored);
    assign busy_o[p] = rst_n && !hit && sb_busy[p];
  end

  assign rd1   = rd_o[0];
  assign rd2   = rd_o[1];
  assign busy1 = busy_o[0];
  assign busy2 = busy_o[1];

endmodule

// File: tb/tb_br_param.sv
// Two register files (default; DEPTH=24/no zero reg/no bypass) on shared inputs,
// checked against an array-based reference model.
module tb_br_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  a1, a2, a3, bsa;
  logic [31:0] wd3;
  logic        we, bs;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        busy1_0, busy2_0, busy1_1, busy2_1;

  int checks = 0;
  int errors = 0;

  int dep [2] = '{32, 24};
  bit zr  [2] = '{1'b1, 1'b0};
  bit byp [2] = '{1'b1, 1'b0};
  logic [31:0] mm [2][32];
  bit          bb [2][32];

  always #5 clk = ~clk;

  br_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .we(we),
    .rd1(rd1_0), .rd2(rd2_0), .bs(bs), .bsa(bsa), .busy1(busy1_0), .busy2(busy2_0)
  );

  br_param #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3), .we(we),
    .rd1(rd1_1), .rd2(rd2_1), .bs(bs), .bsa(bsa), .busy1(busy1_1), .busy2(busy2_1)
  );

  function automatic bit writable(int i, logic [4:0] a);
    return (int'(a) < dep[i]) && !(zr[i] && a == 5'd0);
  endfunction

  function automatic bit fwd(int i, logic [4:0] a);
    return byp[i] && we && a3 == a && writable(i, a3);
  endfunction

  function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
    if (!rst_n || int'(a) >= dep[i]) return 32'd0;
    if (zr[i] && a == 5'd0) return 32'd0;
    if (fwd(i, a)) return wd3;
    return mm[i][a];
  endfunction

  function automatic logic exp_busy(int i, logic [4:0] a);
    if (!rst_n || int'(a) >= dep[i]) return 1'b0;
    if (fwd(i, a)) return 1'b0;
    return bb[i][a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 32; r++) begin
        mm[i][r] = 32'd0;
        bb[i][r] = 1'b0;
      end
  endtask

  // Edge semantics: write clears busy, then busy-set is applied (set wins).
  task automatic model_edge();
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      if (we && writable(i, a3)) begin
        mm[i][a3] = wd3;
        bb[i][a3] = 1'b0;
      end
      if (bs && writable(i, bsa)) bb[i][bsa] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    we = 1'b1; bs = 1'b1; a3 = 5'd3; bsa = 5'd3; wd3 = $urandom;
    for (int a = 0; a < 32; a++) begin
      a1 = 5'(a); a2 = 5'(31 - a); #1;
      checks++;
      if ({rd1_0, rd2_0, busy1_0, busy2_0, rd1_1, rd2_1, busy1_1, busy2_1} !== 132'd0) begin
        errors++; $display("FAIL reset_hold a=%0d got %h/%h/%h/%h exp 0", a, rd1_0, rd2_0, rd1_1, rd2_1);
      end
    end
    tick();
    rst_n = 1'b1; we = 1'b0; bs = 1'b0;
    for (int a = 0; a < 32; a++) begin
      a1 = 5'(a); a2 = 5'(31 - a); #1;
      checks++;
      if ({rd1_0, rd2_0, busy1_0, busy2_0, rd1_1, rd2_1, busy1_1, busy2_1} !== 132'd0) begin
        errors++; $display("FAIL reset_read a=%0d got %h/%h/%h/%h exp 0", a, rd1_0, rd2_0, rd1_1, rd2_1);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; a3 = 5'd1; wd3 = 32'h0000000A; a1 = 5'd2; a2 = 5'd2;
    tick();
    we = 1'b0; a1 = 5'd1; a2 = 5'd2; #1;
    checks++;
    if ({rd1_0, rd2_0, rd1_1, rd2_1} !== {32'hA, 32'h0, 32'hA, 32'h0}) begin
      errors++; $display("FAIL write_read got %h %h %h %h exp a 0 a 0", rd1_0, rd2_0, rd1_1, rd2_1);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; a1 = 5'd0; a2 = 5'd0; #1;
    checks++;
    if ({rd1_0, rd1_1} !== {32'h0, 32'h0}) begin
      errors++; $display("FAIL zero_reg_before got %h %h exp 0 0", rd1_0, rd1_1);
    end
    tick();
    we = 1'b0; #1;
    checks++;
    if ({rd1_0, rd1_1} !== {32'h0, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL zero_reg_after got %h %h exp 0 ffffffff", rd1_0, rd1_1);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; a3 = 5'd5; a1 = 5'd5; a2 = 5'd6; wd3 = 32'h1234; #1;
    checks++;
    if ({rd1_0, rd1_1} !== {32'h1234, 32'h0}) begin
      errors++; $display("FAIL bypass_same_cycle got %h %h exp 1234 0", rd1_0, rd1_1);
    end
    tick();
    we = 1'b0; #1;
    checks++;
    if ({rd1_0, rd1_1} !== {32'h1234, 32'h1234}) begin
      errors++; $display("FAIL bypass_after_edge got %h %h exp 1234 1234", rd1_0, rd1_1);
    end
    we = 1'b1; wd3 = 32'h5678; #1;
    checks++;
    if ({rd1_0, rd1_1} !== {32'h5678, 32'h1234}) begin
      errors++; $display("FAIL bypass_overwrite got %h %h exp 5678 1234", rd1_0, rd1_1);
    end
    tick();
    we = 1'b0;
  endtask

  task automatic test_busy();
    bs = 1'b1; bsa = 5'd7; a1 = 5'd7; a2 = 5'd7; #1;
    checks++;
    if ({busy1_0, busy2_1} !== 2'b00) begin
      errors++; $display("FAIL busy_before_edge got %b%b exp 00", busy1_0, busy2_1);
    end
    tick();
    bs = 1'b0; #1;
    checks++;
    if ({busy1_0, busy2_0, busy1_1, busy2_1} !== 4'b1111) begin
      errors++; $display("FAIL busy_set got %b%b%b%b exp 1111", busy1_0, busy2_0, busy1_1, busy2_1);
    end
    we = 1'b1; a3 = 5'd7; wd3 = 32'd77; #1;
    checks++;
    if ({busy1_0, busy1_1} !== 2'b01) begin
      errors++; $display("FAIL busy_fwd_clear got %b%b exp 01", busy1_0, busy1_1);
    end
    tick();
    we = 1'b0; #1;
    checks++;
    if ({busy1_0, busy1_1} !== 2'b00) begin
      errors++; $display("FAIL busy_write_clear got %b%b exp 00", busy1_0, busy1_1);
    end
    bs = 1'b1; bsa = 5'd7; we = 1'b1; a3 = 5'd7; wd3 = 32'd99;
    tick();
    bs = 1'b0; we = 1'b0; #1;
    checks++;
    if ({busy1_0, busy1_1, rd1_0, rd1_1} !== {2'b11, 32'd99, 32'd99}) begin
      errors++; $display("FAIL busy_set_wins got %b%b %h %h exp 11 63 63", busy1_0, busy1_1, rd1_0, rd1_1);
    end
    bs = 1'b1; bsa = 5'd0;
    tick();
    bs = 1'b0; a1 = 5'd0; #1;
    checks++;
    if ({busy1_0, busy1_1} !== 2'b01) begin
      errors++; $display("FAIL busy_zero_reg got %b%b exp 01", busy1_0, busy1_1);
    end
  endtask

  task automatic test_depth();
    we = 1'b1; a3 = 5'd30; wd3 = 32'h00C0FFEE; bs = 1'b1; bsa = 5'd29;
    tick();
    we = 1'b0; bs = 1'b0; a1 = 5'd30; a2 = 5'd29; #1;
    checks++;
    if ({rd1_1, busy2_1, rd1_0, busy2_0} !== {32'h0, 1'b0, 32'h00C0FFEE, 1'b1}) begin
      errors++; $display("FAIL depth_hole got %h %b %h %b exp 0 0 c0ffee 1", rd1_1, busy2_1, rd1_0, busy2_0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom % 2);
      bs  = ($urandom % 4) == 0;
      a1  = 5'($urandom);
      a2  = (($urandom % 4) == 0) ? a1 : 5'($urandom);
      a3  = (($urandom % 3) == 0) ? a1 : 5'($urandom);
      bsa = (($urandom % 3) == 0) ? a3 : 5'($urandom);
      wd3 = $urandom;
      #1;
      checks++;
      if ({rd1_0, rd2_0, busy1_0, busy2_0} !==
          {exp_rd(0, a1), exp_rd(0, a2), exp_busy(0, a1), exp_busy(0, a2)}) begin
        errors++; $display("FAIL random_dut0 n=%0d got %h %h %b%b exp %h %h %b%b", n, rd1_0, rd2_0,
          busy1_0, busy2_0, exp_rd(0, a1), exp_rd(0, a2), exp_busy(0, a1), exp_busy(0, a2));
      end
      checks++;
      if ({rd1_1, rd2_1, busy1_1, busy2_1} !==
          {exp_rd(1, a1), exp_rd(1, a2), exp_busy(1, a1), exp_busy(1, a2)}) begin
        errors++; $display("FAIL random_dut1 n=%0d got %h %h %b%b exp %h %h %b%b", n, rd1_1, rd2_1,
          busy1_1, busy2_1, exp_rd(1, a1), exp_rd(1, a2), exp_busy(1, a1), exp_busy(1, a2));
      end
      tick();
    end
    we = 1'b0; bs = 1'b0;
  endtask

  task automatic test_async_reset();
    we = 1'b1; a3 = 5'd9; wd3 = 32'h55; bs = 1'b1; bsa = 5'd9;
    tick();
    we = 1'b0; bs = 1'b0; a1 = 5'd9; a2 = 5'd9; #1;
    checks++;
    if ({rd1_0, busy2_0, rd1_1, busy2_1} !== {32'h55, 1'b1, 32'h55, 1'b1}) begin
      errors++; $display("FAIL async_pre got %h %b %h %b exp 55 1 55 1", rd1_0, busy2_0, rd1_1, busy2_1);
    end
    #2;
    rst_n = 1'b0; model_reset();
    we = 1'b1; wd3 = 32'hAA; bs = 1'b1; #1;
    checks++;
    if ({rd1_0, rd2_0, busy1_0, busy2_0, rd1_1, rd2_1, busy1_1, busy2_1} !== 132'd0) begin
      errors++; $display("FAIL async_no_clock got %h %h %h %h exp 0", rd1_0, rd2_0, rd1_1, rd2_1);
    end
    tick();
    rst_n = 1'b1; we = 1'b1; bs = 1'b0; a3 = 5'd9; wd3 = 32'h1111; a2 = 5'd10;
    tick();
    we = 1'b0; #1;
    checks++;
    if ({rd1_0, rd2_0, busy1_0, rd1_1, rd2_1, busy1_1} !== {32'h1111, 32'h0, 1'b0, 32'h1111, 32'h0, 1'b0}) begin
      errors++; $display("FAIL async_first_write got %h %h %h %h exp 1111 0 1111 0", rd1_0, rd2_0, rd1_1, rd2_1);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; bs = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; bsa = '0; wd3 = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_busy();
    test_depth();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
